// File: rtl/l1_burst_scheduler.sv
// Single-outstanding L1 memory scheduler: arbitrates PORTS requesters, issues one command, routes read beats back.
// Define L1_SCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module l1_burst_scheduler #(
  parameter int PORTS     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORTS-1:0]      req,
  input  logic [PORTS-1:0][31:0] req_addr,
  input  logic [PORTS-1:0][31:0] req_data,
  input  logic [PORTS-1:0][3:0] req_be,
  input  logic [PORTS-1:0]      req_rnw,
  input  logic [PORTS-1:0][4:0] req_size,
  output logic [PORTS-1:0]      ack,
  output logic [PORTS-1:0]      resp_valid,
  output logic [31:0]           resp_data,
  output logic                  mem_request,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_data,
  output logic [3:0]            mem_be,
  output logic                  mem_rnw,
  output logic [4:0]            mem_size,
  input  logic                  mem_ack,
  input  logic                  mem_data_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
);
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] win, owner;
  logic [31:0]   addr_q, data_q;
  logic [3:0]    be_q;
  logic          rnw_q;
  logic [4:0]    size_q, size_in, cnt;
  logic          any_req, grant, accept;

  assign any_req = |req;
  assign grant   = (state == IDLE) && any_req;
  assign accept  = (state == ISSUE) && mem_ack;

`ifdef L1_SCHED_ROUND_ROBIN_EN
  logic [IW-1:0] ptr, win_lo, win_hi;
  logic          hi_found;

  // Lowest requester at/after ptr; otherwise wrap to the lowest requester overall.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int j = PORTS-1; j >= 0; j--) begin
      if (req[j]) win_lo = IW'(j);
      if (req[j] && (IW'(j) >= ptr)) begin
        win_hi   = IW'(j);
        hi_found = 1'b1;
      end
    end
    win = hi_found ? win_hi : win_lo;
  end

  always_ff @(posedge clk) begin
    if (rst)         ptr <= '0;
    else if (accept) ptr <= (int'(owner) == PORTS-1) ? '0 : owner + 1'b1;
  end
`else
  always_comb begin
    win = '0;
    for (int j = PORTS-1; j >= 0; j--)
      if (req[j]) win = IW'(j);
  end
`endif

  // Writes are single-beat; reads are capped at the burst limit.
  always_comb begin
    size_in = req_size[win];
    if (!req_rnw[win])                          size_in = '0;
    else if (int'(req_size[win]) >= MAX_BURST) size_in = 5'(MAX_BURST - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ack         = '0;
    resp_valid  = '0;
    mem_request = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        mem_request = 1'b1;
        if (mem_ack) begin
          ack[owner] = 1'b1;
          state_nxt  = rnw_q ? BURST : IDLE;
        end
      end
      BURST: begin
        resp_valid[owner] = mem_data_valid;
        if (mem_data_valid && (cnt == size_q)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A reset cycle abandons the transaction before anything is signalled.
    if (rst) begin
      ack         = '0;
      resp_valid  = '0;
      mem_request = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  cnt <= '0;
    else if (accept)                          cnt <= '0;
    else if (state == BURST && mem_data_valid) cnt <= (cnt == size_q) ? '0 : cnt + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= '0;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      rnw_q  <= 1'b0;
      size_q <= '0;
    end else if (grant) begin
      owner  <= win;
      addr_q <= req_addr[win];
      data_q <= req_data[win];
      be_q   <= req_be[win];
      rnw_q  <= req_rnw[win];
      size_q <= size_in;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign mem_be    = be_q;
  assign mem_rnw   = rnw_q;
  assign mem_size  = size_q;
  assign resp_data = mem_rdata;
  assign busy      = (state != IDLE) && !rst;
endmodule

// File: tb/tb_l1_burst_scheduler.sv
// Scoreboard bench for l1_burst_scheduler: stimulus queues expected acks/beats, a negedge monitor checks them.
module tb_l1_burst_scheduler;
  localparam int PORTS     = 2;
  localparam int MAX_BURST = 16;
  localparam int PW        = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [PORTS-1:0]       req;
  logic [PORTS-1:0][31:0] req_addr, req_data;
  logic [PORTS-1:0][3:0]  req_be;
  logic [PORTS-1:0]       req_rnw;
  logic [PORTS-1:0][4:0]  req_size;
  logic [PORTS-1:0]       ack, resp_valid;
  logic [31:0]            resp_data;
  logic                   mem_request, mem_rnw, mem_ack, mem_data_valid, busy;
  logic [31:0]            mem_addr, mem_data, mem_rdata;
  logic [3:0]             mem_be;
  logic [4:0]             mem_size;

  always #5 clk = ~clk;

  l1_burst_scheduler #(.PORTS(PORTS), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_be(req_be), .req_rnw(req_rnw), .req_size(req_size), .ack(ack),
    .resp_valid(resp_valid), .resp_data(resp_data), .mem_request(mem_request),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_rnw(mem_rnw),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_data_valid(mem_data_valid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic [PORTS-1:0] ack;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0]       be;
    logic             rnw;
    logic [4:0]       size;
  } ack_exp_t;

  typedef struct {
    logic [PORTS-1:0] vld;
    logic [31:0]      data;
  } beat_exp_t;

  ack_exp_t  aq[$];
  beat_exp_t bq[$];
  ack_exp_t  ea;
  beat_exp_t eb;
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack or read beat the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (|ack) begin
      if (aq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_ack: got ack=%b, expected none", ack);
      end else begin
        ea = aq.pop_front();
        chk("ack_port", 32'(ack), 32'(ea.ack));
        chk("ack_addr", mem_addr, ea.addr);
        chk("ack_rnw",  32'(mem_rnw), 32'(ea.rnw));
        chk("ack_size", 32'(mem_size), 32'(ea.size));
        chk("ack_be",   32'(mem_be), 32'(ea.be));
        if (!ea.rnw) chk("ack_wdata", mem_data, ea.data);
      end
    end
    if (|resp_valid) begin
      if (bq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_beat: got resp_valid=%b data=%h, expected none", resp_valid, resp_data);
      end else begin
        eb = bq.pop_front();
        chk("beat_port", 32'(resp_valid), 32'(eb.vld));
        chk("beat_data", resp_data, eb.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input logic [PW-1:0] p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic rnw, input logic [4:0] size);
    req_addr[p] = addr;
    req_data[p] = data;
    req_be[p]   = be;
    req_rnw[p]  = rnw;
    req_size[p] = size;
  endtask

  task automatic expect_ack(input logic [PW-1:0] p, input logic [4:0] exp_size);
    ack_exp_t e;
    e.ack     = '0;
    e.ack[p]  = 1'b1;
    e.addr    = req_addr[p];
    e.data    = req_data[p];
    e.be      = req_be[p];
    e.rnw     = req_rnw[p];
    e.size    = exp_size;
    aq.push_back(e);
  endtask

  // Wait (bounded) for the command, hold it dly cycles checking stability, then accept it.
  task automatic handshake(input int dly);
    bit ok = 1'b0;
    ack_exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (mem_request) begin ok = 1'b1; break; end
      tick();
    end
    chk("issue_seen", 32'(ok), 32'd1);
    if (aq.size() != 0) e = aq[0];
    for (int d = 0; d < dly; d++) begin
      chk("hold_request", 32'(mem_request), 32'd1);
      chk("hold_addr", mem_addr, e.addr);
      chk("hold_data", mem_data, e.data);
      chk("hold_be",   32'(mem_be), 32'(e.be));
      chk("hold_size", 32'(mem_size), 32'(e.size));
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic beats(input logic [PW-1:0] p, input int n, input logic [31:0] base, input bit gap);
    beat_exp_t b;
    for (int i = 0; i < n; i++) begin
      b.vld    = '0;
      b.vld[p] = 1'b1;
      b.data   = base + 32'(i);
      bq.push_back(b);
      mem_data_valid = 1'b1;
      mem_rdata      = base + 32'(i);
      tick();
      mem_data_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  logic [PW-1:0] exp_win [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0; req_be = '0; req_rnw = '0;
    req_size = '0; mem_ack = 1'b0; mem_data_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_request", 32'(mem_request), 32'd0);

    // Port 1 read of 4 beats, accepted in the second ISSUE cycle.
    set_port(1'd1, 32'h1000, 32'h0, 4'hF, 1'b1, 5'd3);
    expect_ack(1'd1, 5'd3);
    req = 2'b10;
    tick();
    chk("min_latency", 32'(mem_request), 32'd1);
    handshake(1);
    req = '0;
    beats(1'd1, 4, 32'hA, 1'b0);
    chk("read4_idle", 32'(busy), 32'd0);

    // Port 0 write with slow memory accept; size forced to 0.
    set_port(1'd0, 32'h2004, 32'hDEADBEEF, 4'h3, 1'b0, 5'd9);
    expect_ack(1'd0, 5'd0);
    req = 2'b01;
    tick();
    handshake(5);
    req = '0;
    chk("write_idle", 32'(busy), 32'd0);

    // Stray read data while idle must be ignored.
    mem_data_valid = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_data_valid = 1'b0;
    chk("stray_idle_busy", 32'(busy), 32'd0);

    // Oversized read clamps to 16 beats; gaps between beats must not advance the counter.
    set_port(1'd0, 32'h3000, 32'h0, 4'hF, 1'b1, 5'd31);
    expect_ack(1'd0, 5'd15);
    req = 2'b01;
    tick();
    handshake(0);
    req = '0;
    beats(1'd0, 16, 32'h100, 1'b1);
    chk("clamp_idle", 32'(busy), 32'd0);

    // Reset on the second of 8 beats abandons the burst.
    set_port(1'd1, 32'h4000, 32'h0, 4'hF, 1'b1, 5'd7);
    expect_ack(1'd1, 5'd7);
    req = 2'b10;
    tick();
    handshake(0);
    req = '0;
    beats(1'd1, 1, 32'h70, 1'b0);
    mem_data_valid = 1'b1; mem_rdata = 32'h71; rst = 1'b1;
    tick();
    rst = 1'b0; mem_rdata = 32'h72;
    tick(); tick(); tick();
    mem_data_valid = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_request", 32'(mem_request), 32'd0);
    set_port(1'd1, 32'h5000, 32'h12345678, 4'hC, 1'b0, 5'd0);
    expect_ack(1'd1, 5'd0);
    req = 2'b10;
    tick();
    handshake(2);
    req = '0;
    tick();
    chk("post_rst_txn_idle", 32'(busy), 32'd0);

    // Both ports requesting continuously.
`ifdef L1_SCHED_ROUND_ROBIN_EN
    exp_win[0] = 1'd0; exp_win[1] = 1'd1; exp_win[2] = 1'd0; exp_win[3] = 1'd1;
`else
    exp_win[0] = 1'd0; exp_win[1] = 1'd0; exp_win[2] = 1'd0; exp_win[3] = 1'd0;
`endif
    set_port(1'd0, 32'h6000, 32'hA0A0A0A0, 4'hF, 1'b0, 5'd0);
    set_port(1'd1, 32'h7000, 32'hB1B1B1B1, 4'h5, 1'b0, 5'd0);
    req = 2'b11;
    tick();
    for (int t = 0; t < 4; t++) begin
      expect_ack(exp_win[t], 5'd0);
      handshake(0);
    end
    req = '0;
    tick();
    chk("arb_idle", 32'(busy), 32'd0);

    tick(); tick();
    chk("ack_queue_drained", 32'(aq.size()), 32'd0);
    chk("beat_queue_drained", 32'(bq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/l1_burst_scheduler.md
L1_BURST_SCHEDULER -- requirements
Module: l1_burst_scheduler

Interface
REQ-001 SHALL have parameter PORTS, default 2, number of requesters (legal 2..4; port 0 is dcache, port 1 is icache).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum read burst length in words.
REQ-003 SHALL have port clk  input  1  sole clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  PORTS  per-port request, held by the requester until acked.
REQ-006 SHALL have port req_addr  input  PORTS x 32  word-aligned address per port.
REQ-007 SHALL have port req_data / req_be / req_rnw / req_size  input  PORTS x 32 / x4 / x1 / x5  write data, byte enables, read-not-write, burst length minus one.
REQ-008 SHALL have port ack  output  PORTS  one-cycle accept pulse per port.
REQ-009 SHALL have port resp_valid  output  PORTS  read beat valid for the owning port.
REQ-010 SHALL have port resp_data  output  32  read data, broadcast to all ports.
REQ-011 SHALL have ports mem_request, mem_addr[31:0], mem_data[31:0], mem_be[3:0], mem_rnw, mem_size[4:0]  output  memory-side command.
REQ-012 SHALL have ports mem_ack, mem_data_valid, mem_rdata[31:0]  input  memory-side accept and read return.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement three states: IDLE, ISSUE, BURST.
REQ-015 In IDLE with any req bit high, SHALL register the winner index and its address, data, be, rnw and size, then enter ISSUE on the next cycle.
REQ-016 In ISSUE, SHALL drive mem_request=1 with the latched fields, and hold them unchanged until mem_ack.
REQ-017 On mem_ack in ISSUE, SHALL pulse ack for the winner in the same cycle.
REQ-018 On mem_ack in ISSUE for a write, SHALL return to IDLE; for a read, SHALL enter BURST with the beat counter at 0.
REQ-019 In BURST, resp_valid[owner] SHALL equal mem_data_valid combinationally, and resp_data SHALL equal mem_rdata; resp_valid for other ports SHALL be 0.
REQ-020 The beat counter SHALL increment on each mem_data_valid; the beat on which counter == latched size SHALL be the last, and the next state SHALL be IDLE.
REQ-021 SHALL grant no new request while in ISSUE or BURST (one outstanding transaction).
REQ-022 mem_size SHALL be forced to 0 for writes; a read size >= MAX_BURST SHALL be clamped to MAX_BURST-1.
REQ-023 mem_data_valid outside BURST SHALL be ignored: no resp_valid and no counter change.
REQ-024 A req bit dropped before ack SHALL NOT cancel an already-latched grant.
REQ-025 Minimum request-to-ack latency SHALL be 1 cycle (req sampled in IDLE, ack at the earliest in ISSUE the next cycle).

Reset
REQ-026 On rst: state=IDLE, beat counter=0, priority pointer=0, ack=0, resp_valid=0, mem_request=0, busy=0.
REQ-027 rst mid-ISSUE or mid-BURST SHALL abandon the transaction, produce no ack or resp_valid in the reset cycle, and discard remaining beats.

Configuration
REQ-028 Macro L1_SCHED_ROUND_ROBIN_EN SHALL select arbitration.
REQ-029 With L1_SCHED_ROUND_ROBIN_EN defined, winner = first requesting port at or after the pointer, wrapping; on each ack the pointer becomes (winner+1) mod PORTS.
REQ-030 Without L1_SCHED_ROUND_ROBIN_EN, the lowest-index requesting port SHALL win, the pointer SHALL be absent, and port 0 SHALL always beat port 1.

Verification
REQ-031 Port 1 read addr 0x1000 size 3, mem_ack in cycle 2, 4 beats 0xA..0xD -> ack[1] for one cycle, resp_valid[1] x4 with data 0xA..0xD, IDLE after the 4th beat.
REQ-032 Port 0 write addr 0x2004 be 0x3 data 0xDEADBEEF, mem_ack delayed 5 cycles -> mem_request held 5 cycles with stable fields, mem_size=0, ack[0] coincident with mem_ack.
REQ-033 req=2'b11 continuously, 4 transactions -> RR build grants 0,1,0,1; non-RR build grants 0,0,0,0.
REQ-034 rst asserted on the 2nd of 8 beats -> no further resp_valid; a stray mem_data_valid after reset is ignored; the next request proceeds normally.
REQ-035 Read size 31 with MAX_BURST=16 -> mem_size=15, exactly 16 beats routed, then IDLE.
REQ-036 mem_data_valid pulsed while IDLE -> resp_valid stays 0 and the counter stays 0.
